hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Multiply/divide control unit between the CPU execute stage and the iterative divider instances.
- Owns the architectural HI/LO registers.
- Runs MULT/MULTU on an internal 32-cycle shift-add multiplier.
- Sequences DIV/DIVU through two external dividers (one signed, one unsigned), captures their {remainder, quotient} result into HI/LO, and stalls the pipeline while busy.

Parameters:
- WIDTH, 32, operand width; HI/LO width; divider result is 2*WIDTH.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clock.
- op_valid  in  1  op is presented this cycle.
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NOP.
- rs_data  in  WIDTH  operand A / dividend / MTHI-MTLO source.
- rt_data  in  WIDTH  operand B / divisor.
- stall  out  1  pipeline hold, combinational.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_dividend  out  WIDTH  registered copy of rs_data; shared by both dividers.
- div_divisor  out  WIDTH  registered copy of rt_data; shared by both dividers.
- div_start  out  1  signed divider start level.
- div_ready  in  1  signed divider result valid.
- div_z  in  2*WIDTH  {remainder, quotient}, signed.
- divu_start  out  1  unsigned divider start level.
- divu_ready  in  1  unsigned divider result valid.
- divu_z  in  2*WIDTH  {remainder, quotient}, unsigned.

Behaviour:
- Reset values: hi = 0, lo = 0, div_start = 0, divu_start = 0, div_dividend = 0, div_divisor = 0, state = IDLE. The multiplier accumulator is cleared.
- Divider protocol:
  - The start level must be held high for the whole operation.
  - Start low clears the divider.
  - The controller drops start on the same edge at which it samples ready = 1.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - MTHI/MTLO: hi or lo <= rs_data at the edge. Stall stays 0.
  - MFHI/MFLO/NOP: no action. Stall stays 0.
  - MULT/MULTU: stall = 1. At the edge, latch operand magnitudes (magnitudes only for MULT) and the result sign (MULT only), clear the accumulator, count <= 0, go to MUL.
  - DIV/DIVU with rt_data != 0: stall = 1. At the edge, latch div_dividend/div_divisor, assert the selected start, go to DIV.
  - DIV/DIVU with rt_data == 0: single-cycle, no stall. hi <= rs_data, lo <= all ones; the divider is not started.
- MUL:
  - stall = 1. One add-shift per cycle for 32 cycles.
  - On the 32nd edge: write {hi, lo} = product (two's-complement negated if the sign bit is set), go to DONE.
  - Total: stall high for 33 cycles, including the accept cycle.
- DIV:
  - stall = 1. Wait for the selected ready.
  - On the edge with ready = 1: hi <= z[2W-1:W], lo <= z[W-1:0], start <= 0, go to DONE.
  - The other divider's ready is ignored.
- DONE:
  - stall = 0. The op on the bus is the retiring instruction and is ignored.
  - Next edge: go to IDLE.
- Stall while state ≠ IDLE and ≠ DONE: any op is held. MFHI/MFLO therefore never read stale HI/LO.
- op_valid = 0: treated as NOP in every state.
- Reset mid-operation: immediate return to IDLE with both starts low, aborting the divider. HI/LO return to 0.
- MULTU on the full 32-bit range: the product is exact with no overflow; the 64-bit result is stored.

Decomposition:
- Package mdu_pkg: op encoding constants, state enum, WIDTH default.
- Sub-module mdu_mul_iter: the 32-cycle unsigned shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, 64-bit product.
- Sign fix-up and HI/LO stay in the top level.

Test Plan:
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> hi = 0x12345678, lo = 0x9ABCDEF0; stall never high.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 -> stall high 33 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV rs = 0xFFFFFFF9 (-7), rt = 2 with a behavioural signed divider -> div_start held until div_ready, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFD. div_start is low the cycle after ready.
- DIVU rs = 0x80000000, rt = 3 -> only divu_start asserted; hi = 0x00000002, lo = 0x2AAAAAAA.
- DIV rt = 0, rs = 0x55 -> no stall, no start; hi = 0x55, lo = 0xFFFFFFFF.
- Reset asserted at cycle 10 of a DIV -> div_start low asynchronously, stall 0, hi = lo = 0. A following MFHI during a MULT stalls until DONE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the HI/LO multiply/divide control unit.
// Op encoding, controller state codes and the default operand width.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mdu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles.
// done/product are combinational on the last iteration so the owner can write the result that edge.
module mdu_mul_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: runs MULT/MULTU on the local iterative multiplier and sequences
// DIV/DIVU through the external signed/unsigned dividers, stalling while busy.
module hilo_muldiv_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  output logic               stall,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  output logic               div_start,
  input  logic               div_ready,
  input  logic [2*WIDTH-1:0] div_z,
  output logic               divu_start,
  input  logic               divu_ready,
  input  logic [2*WIDTH-1:0] divu_z
);

  logic [1:0]         state;
  logic [3:0]         op_eff;
  logic               idle, is_mul, is_div, rt_zero;
  logic               accept_mul, accept_div, mul_sgn;
  logic               mul_neg, div_uns;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod, prod_fix;
  logic               sel_ready;
  logic [2*WIDTH-1:0] sel_z;

  assign op_eff     = op_valid ? op : OP_NOP;
  assign idle       = (state == ST_IDLE);
  assign is_mul     = (op_eff == OP_MULT) || (op_eff == OP_MULTU);
  assign is_div     = (op_eff == OP_DIV) || (op_eff == OP_DIVU);
  assign rt_zero    = (rt_data == '0);
  assign accept_mul = idle && is_mul;
  assign accept_div = idle && is_div && !rt_zero;
  assign stall      = accept_mul || accept_div || (state == ST_MUL) || (state == ST_DIV);

  // Signed multiply runs on magnitudes; -2^(W-1) negates to itself, which is the right unsigned magnitude.
  assign mul_sgn  = (op_eff == OP_MULT);
  assign a_mag    = (mul_sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign b_mag    = (mul_sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  assign prod_fix = mul_neg ? -mul_prod : mul_prod;

  assign sel_ready = div_uns ? divu_ready : div_ready;
  assign sel_z     = div_uns ? divu_z : div_z;

  mdu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (accept_mul),
    .a       (a_mag),
    .b       (b_mag),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      hi           <= '0;
      lo           <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_start    <= 1'b0;
      divu_start   <= 1'b0;
      mul_neg      <= 1'b0;
      div_uns      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_mul) begin
            mul_neg <= mul_sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            state   <= ST_MUL;
          end else if (accept_div) begin
            div_dividend <= rs_data;
            div_divisor  <= rt_data;
            div_uns      <= (op_eff == OP_DIVU);
            div_start    <= (op_eff == OP_DIV);
            divu_start   <= (op_eff == OP_DIVU);
            state        <= ST_DIV;
          end else begin
            case (op_eff)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              // Divide by zero retires immediately without touching the dividers.
              OP_DIV, OP_DIVU: begin
                hi <= rs_data;
                lo <= '1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            {hi, lo} <= prod_fix;
            state    <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (sel_ready) begin
            hi         <= sel_z[2*WIDTH-1:WIDTH];
            lo         <= sel_z[WIDTH-1:0];
            div_start  <= 1'b0;
            divu_start <= 1'b0;
            state      <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl with behavioural signed/unsigned dividers.
module tb_hilo_muldiv_ctrl;
  import mdu_pkg::*;

  localparam int W     = 32;
  localparam int DLAT  = 12;
  localparam int DULAT = 7;

  logic           clock = 1'b0;
  logic           reset;
  logic           op_valid;
  logic [3:0]     op;
  logic [W-1:0]   rs_data, rt_data;
  logic           stall;
  logic [W-1:0]   hi, lo, div_dividend, div_divisor;
  logic           div_start, div_ready, divu_start, divu_ready;
  logic [2*W-1:0] div_z, divu_z;

  always #5 clock = ~clock;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op           (op),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_start    (div_start),
    .div_ready    (div_ready),
    .div_z        (div_z),
    .divu_start   (divu_start),
    .divu_ready   (divu_ready),
    .divu_z       (divu_z)
  );

  // Behavioural dividers: fixed latency while start is held, cleared when start drops.
  int dcnt, ducnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dcnt  <= 0;
      ducnt <= 0;
    end else begin
      if (!div_start) dcnt <= 0;
      else if (dcnt != DLAT) dcnt <= dcnt + 1;
      if (!divu_start) ducnt <= 0;
      else if (ducnt != DULAT) ducnt <= ducnt + 1;
    end
  end
  assign div_ready  = div_start && (dcnt == DLAT);
  assign divu_ready = divu_start && (ducnt == DULAT);

  always_comb begin
    div_z  = '0;
    divu_z = '0;
    if (div_divisor != '0) begin
      div_z  = {$signed(div_dividend) % $signed(div_divisor), $signed(div_dividend) / $signed(div_divisor)};
      divu_z = {div_dividend % div_divisor, div_dividend / div_divisor};
    end
  end

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           stalls;
    logic [1:0]   seen;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input bit vld, input logic [3:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int estalls, input logic [1:0] eseen);
    exp_t e, g;
    int st;
    logic [1:0] seen, at_end;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.stalls = estalls; e.seen = eseen;
    sb.push_back(e);
    @(negedge clock);
    op_valid = vld; op = o; rs_data = a; rt_data = b;
    #1;
    st = 0; seen = '0;
    while (stall && st < 200) begin
      seen |= {div_start, divu_start};
      st++;
      @(negedge clock);
      #1;
    end
    at_end = {div_start, divu_start};
    @(negedge clock);
    op_valid = 1'b0; op = OP_NOP;
    #1;
    g = sb.pop_front();
    chk({g.tag, "_hi"}, 64'(hi), 64'(g.hi));
    chk({g.tag, "_lo"}, 64'(lo), 64'(g.lo));
    chk({g.tag, "_stalls"}, 64'(st), 64'(g.stalls));
    chk({g.tag, "_starts_seen"}, 64'(seen), 64'(g.seen));
    chk({g.tag, "_starts_at_retire"}, 64'(at_end), 64'(0));
  endtask

  initial begin
    int st;
    reset = 1'b1; op_valid = 1'b0; op = OP_NOP; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_starts", 64'({div_start, divu_start}), 64'(0));
    chk("rst_dividend", 64'(div_dividend), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    run_op("mthi",  1, OP_MTHI,  32'h12345678, 32'h0, 32'h12345678, 32'h00000000, 0, 2'b00);
    run_op("mtlo",  1, OP_MTLO,  32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0, 2'b00);
    run_op("mfhi",  1, OP_MFHI,  32'hDEADBEEF, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0, 2'b00);
    run_op("op12",  1, 4'd12,    32'hDEADBEEF, 32'h1, 32'h12345678, 32'h9ABCDEF0, 0, 2'b00);
    run_op("novld", 0, OP_MULT,  32'h5,        32'h6, 32'h12345678, 32'h9ABCDEF0, 0, 2'b00);
    run_op("mult_neg3x7",  1, OP_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 2'b00);
    run_op("multu_max",    1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 2'b00);
    run_op("mult_minx2",   1, OP_MULT,  32'h80000000, 32'h2,        32'hFFFFFFFF, 32'h00000000, 33, 2'b00);
    run_op("mult_neg5x6n", 1, OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 33, 2'b00);
    run_op("div_neg7by2",  1, OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DLAT + 2, 2'b10);
    run_op("divu_big",     1, OP_DIVU,  32'h80000000, 32'h3,        32'h00000002, 32'h2AAAAAAA, DULAT + 2, 2'b01);
    chk("divu_dividend", 64'(div_dividend), 64'(32'h80000000));
    chk("divu_divisor",  64'(div_divisor),  64'(32'h3));
    run_op("div_by_zero",  1, OP_DIV,   32'h00000055, 32'h0,        32'h00000055, 32'hFFFFFFFF, 0, 2'b00);

    // Abort a divide with reset part-way through.
    @(negedge clock);
    op_valid = 1'b1; op = OP_DIV; rs_data = 32'd100; rt_data = 32'd7;
    repeat (10) @(negedge clock);
    #1;
    chk("abort_pre_start", 64'(div_start), 64'(1));
    #1;
    reset = 1'b1; op_valid = 1'b0; op = OP_NOP;
    #1;
    chk("abort_div_start", 64'(div_start), 64'(0));
    chk("abort_stall", 64'(stall), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // MFHI arriving behind a MULT is held until the result is in HI/LO.
    @(negedge clock);
    op_valid = 1'b1; op = OP_MULT; rs_data = 32'hFFFFFFFF; rt_data = 32'h1;
    #1;
    chk("mfhi_hold_accept_stall", 64'(stall), 64'(1));
    @(negedge clock);
    op = OP_MFHI;
    #1;
    st = 0;
    while (stall && st < 200) begin
      st++;
      @(negedge clock);
      #1;
    end
    chk("mfhi_hold_stalls", 64'(st), 64'(32));
    chk("mfhi_hold_hi", 64'(hi), 64'(32'hFFFFFFFF));
    chk("mfhi_hold_lo", 64'(lo), 64'(32'hFFFFFFFF));
    @(negedge clock);
    op_valid = 1'b0; op = OP_NOP;
    #1;
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
